// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding and default 8/5 LFSR/MISR constants for the BIST engine.
package bist_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CMP, DONE} state_t;
  localparam logic [7:0] DEF_TAPS = 8'hB8;
  localparam logic [7:0] DEF_SEED = 8'h01;
  localparam logic [4:0] DEF_POLY = 5'h14;
  localparam logic [4:0] DEF_INIT = 5'h00;
endpackage

// File: rtl/bist_fsr.sv
// bist_fsr: feedback shift register, an LFSR with d tied to zero or a MISR when d carries a response.
module bist_fsr #(
  parameter int W = 8,
  parameter logic [W-1:0] MASK = '0,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst || load) q <= INIT;
    else if (step) q <= {q[W-2:0], ^(q & MASK)} ^ d;
endmodule

// File: rtl/bist_engine.sv
// bist_engine: LFSR pattern generator plus MISR compactor with run control, abort and golden compare.
module bist_engine
  import bist_pkg::*;
#(
  parameter int LFSR_W = 8,
  parameter int SIG_W = 5,
  parameter int CNT_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = DEF_TAPS,
  parameter logic [SIG_W-1:0] POLY = DEF_POLY,
  parameter logic [LFSR_W-1:0] SEED = DEF_SEED,
  parameter logic [SIG_W-1:0] INIT = DEF_INIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  test_cycles,
  input  logic [SIG_W-1:0]  golden,
  input  logic [SIG_W-1:0]  dut_resp,
  output logic [LFSR_W-1:0] pattern,
  output logic              pattern_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  cycles_run
);
  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;
  state_t state, nxt;
  logic [CNT_W-1:0] len, cnt;
  logic pass_r, ld, accept;
  assign pattern_valid = state == RUN;
  assign busy = state inside {LOAD, RUN, CMP};
  assign done = state == DONE;
  assign pass = pass_r;
  assign cycles_run = cnt;
  assign ld = state == LOAD && !abort;
  assign accept = (state == IDLE || state == DONE) && start && !abort;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = (len == '0) ? CMP : RUN;
      RUN:     nxt = (cnt == len - CNT_W'(1)) ? CMP : RUN;
      CMP:     nxt = DONE;
      DONE:    nxt = start ? LOAD : DONE;
      default: nxt = IDLE;
    endcase
    nxt = abort ? IDLE : nxt;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      len    <= '0;
      cnt    <= '0;
      pass_r <= 1'b0;
    end else begin
      state  <= nxt;
      if (accept) len <= test_cycles;
      if (ld) cnt <= '0;
      else if (pattern_valid) cnt <= cnt + CNT_W'(1);
      // pass only survives while sitting in DONE; any exit clears it
      pass_r <= (state == CMP && !abort) ? (signature == golden) :
                (state == DONE && !abort && !start) ? pass_r : 1'b0;
    end
  bist_fsr #(.W(LFSR_W), .MASK(TAPS), .INIT(SEED_NZ)) u_lfsr (
    .clk(clk), .rst(rst), .load(ld), .step(pattern_valid), .d('0), .q(pattern)
  );
  bist_fsr #(.W(SIG_W), .MASK(POLY), .INIT(INIT)) u_misr (
    .clk(clk), .rst(rst), .load(ld), .step(pattern_valid), .d(dut_resp), .q(signature)
  );
endmodule

// File: tb/tb_bist_engine.sv
// tb_bist_engine: directed checks of the BIST engine with hand-computed LFSR/MISR values.
module tb_bist_engine;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [15:0] test_cycles = 0;
  logic [4:0] golden = 0, dut_resp = 0;
  logic [7:0] pattern;
  logic pattern_valid, busy, done, pass;
  logic [4:0] signature;
  logic [15:0] cycles_run;
  int tests = 0, fails = 0;

  bist_engine dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .test_cycles(test_cycles),
    .golden(golden), .dut_resp(dut_resp), .pattern(pattern), .pattern_valid(pattern_valid),
    .busy(busy), .done(done), .pass(pass), .signature(signature), .cycles_run(cycles_run)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_done(input int n, output int lat);
    test_cycles = 16'(n);
    start = 1;
    tick();
    start = 0;
    lat = 1;
    while (!done && lat < n + 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tests++;
    if ({busy, done, pass, pattern_valid} !== 4'b0 || pattern !== 8'h01 || signature !== 5'h00 || cycles_run !== 16'd0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b pass=%b pv=%b pattern=%h sig=%h cyc=%0d, need 0 0 0 0 01 00 0",
               busy, done, pass, pattern_valid, pattern, signature, cycles_run);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_pat [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    dut_resp = 0; golden = 0; test_cycles = 4;
    start = 1;
    tick();
    start = 0;
    tests++;
    if (busy !== 1'b1 || pattern_valid !== 1'b0) begin
      fails++; $display("FAIL basic_load: busy=%b pv=%b, need 1 0", busy, pattern_valid);
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      tests++;
      if (pattern !== exp_pat[c-2] || pattern_valid !== 1'b1) begin
        fails++; $display("FAIL basic_pattern c%0d: pattern=%h pv=%b, need %h 1", c, pattern, pattern_valid, exp_pat[c-2]);
      end
    end
    tick();
    tests++;
    if (pattern !== 8'h11 || pattern_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_cmp: pattern=%h pv=%b done=%b busy=%b, need 11 0 0 1", pattern, pattern_valid, done, busy);
    end
    tick();
    tests++;
    if (done !== 1'b1 || pass !== 1'b1 || signature !== 5'h00 || cycles_run !== 16'd4 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_done: done=%b pass=%b sig=%h cyc=%0d busy=%b, need 1 1 00 4 0", done, pass, signature, cycles_run, busy);
    end
  endtask

  task automatic test_zero_len();
    logic pv_seen = 0;
    dut_resp = 0; golden = 0; test_cycles = 0;
    start = 1;
    tick();
    start = 0;
    pv_seen |= pattern_valid;
    for (int c = 2; c <= 3; c++) begin
      tick();
      pv_seen |= pattern_valid;
      tests++;
      if (done !== (c == 3)) begin
        fails++; $display("FAIL zero_done c%0d: done=%b, need %b", c, done, c == 3);
      end
    end
    tests++;
    if (pass !== 1'b1 || pv_seen !== 1'b0 || cycles_run !== 16'd0) begin
      fails++; $display("FAIL zero_result: pass=%b pv_seen=%b cyc=%0d, need 1 0 0", pass, pv_seen, cycles_run);
    end
  endtask

  task automatic test_misr();
    int lat;
    dut_resp = 5'h01; golden = 5'h01;
    run_done(1, lat);
    tests++;
    if (lat !== 4 || signature !== 5'h01 || pass !== 1'b1) begin
      fails++; $display("FAIL misr_n1: lat=%0d sig=%h pass=%b, need 4 01 1", lat, signature, pass);
    end
    golden = 5'h03;
    run_done(2, lat);
    tests++;
    if (lat !== 5 || signature !== 5'h03 || pass !== 1'b1) begin
      fails++; $display("FAIL misr_n2_good: lat=%0d sig=%h pass=%b, need 5 03 1", lat, signature, pass);
    end
    golden = 5'h02;
    run_done(2, lat);
    tests++;
    if (done !== 1'b1 || signature !== 5'h03 || pass !== 1'b0) begin
      fails++; $display("FAIL misr_n2_bad: done=%b sig=%h pass=%b, need 1 03 0", done, signature, pass);
    end
  endtask

  task automatic test_back_to_back();
    dut_resp = 0; golden = 0; test_cycles = 64;
    start = 1;
    tick();
    start = 0;
    for (int c = 2; c <= 67; c++) begin
      if (c == 10) start = 1;
      if (c == 11) start = 0;
      tick();
      if (c >= 66) begin
        tests++;
        if (done !== (c == 67)) begin
          fails++; $display("FAIL b2b_done c%0d: done=%b, need %b", c, done, c == 67);
        end
      end
    end
    tests++;
    if (cycles_run !== 16'd64 || pass !== 1'b1) begin
      fails++; $display("FAIL b2b_result: cyc=%0d pass=%b, need 64 1", cycles_run, pass);
    end
    start = 1;
    tick();
    start = 0;
    tests++;
    if (done !== 1'b0 || busy !== 1'b1 || pass !== 1'b0) begin
      fails++; $display("FAIL b2b_restart: done=%b busy=%b pass=%b, need 0 1 0", done, busy, pass);
    end
  endtask

  task automatic test_abort();
    abort = 1;
    tick();
    abort = 0;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL abort_flush: busy=%b, need 0", busy);
    end
    dut_resp = 0; test_cycles = 64;
    start = 1;
    tick();
    start = 0;
    for (int c = 2; c <= 5; c++) tick();
    abort = 1;
    tick();
    abort = 0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || cycles_run !== 16'd4 || pattern !== 8'h11) begin
      fails++; $display("FAIL abort_run: busy=%b done=%b pass=%b cyc=%0d pattern=%h, need 0 0 0 4 11",
                        busy, done, pass, cycles_run, pattern);
    end
    abort = 1; start = 1;
    tick();
    abort = 0; start = 0;
    tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || cycles_run !== 16'd4) begin
      fails++; $display("FAIL abort_start: busy=%b done=%b cyc=%0d, need 0 0 4", busy, done, cycles_run);
    end
  endtask

  task automatic test_rst_mid();
    dut_resp = 5'h01; test_cycles = 64;
    start = 1;
    tick();
    start = 0;
    for (int c = 2; c <= 4; c++) tick();
    rst = 1; abort = 1; start = 1;
    tick();
    rst = 0; abort = 0; start = 0;
    tests++;
    if ({busy, done, pass, pattern_valid} !== 4'b0 || pattern !== 8'h01 || signature !== 5'h00 || cycles_run !== 16'd0) begin
      fails++; $display("FAIL rst_mid: busy=%b done=%b pass=%b pv=%b pattern=%h sig=%h cyc=%0d, need 0 0 0 0 01 00 0",
                        busy, done, pass, pattern_valid, pattern, signature, cycles_run);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_misr();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
